dest_reg_pipeline: RTL and testbench

Destination-register tracking pipeline that sits directly upstream of the forwarding logic. It registers the decode-stage destination register through the EX, MEM and WB stages, and drives the RT2/RT3/RT4 compare inputs. It consumes the resulting `stall` request to insert bubbles and hold fetch/decode. It also applies branch flush and memory-wait freeze, and keeps a saturating stall counter with a stuck-stall watchdog.

---
 rtl/dest_reg_pipeline_if.sv | 31 +++
 rtl/dest_reg_pipeline.sv | 76 +++++++
 tb/tb_dest_reg_pipeline.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dest_reg_pipeline_if.sv
// rtl/dest_reg_pipeline_if.sv - decode/forwarding side bundle for the destination-register pipeline
interface dest_reg_pipeline_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       idRt;
    logic             idWrite;
    logic             idValid;
    logic             stall;
    logic             flush;
    logic             memWait;
    logic [3:0]       RT2;
    logic [3:0]       RT3;
    logic [3:0]       RT4;
    logic             v2;
    logic             v3;
    logic             v4;
    logic             ifIdEn;
    logic             idKill;
    logic [CNT_W-1:0] stallCount;
    logic             stallError;

    modport master (
        output idRt, idWrite, idValid, stall, flush, memWait,
        input  RT2, RT3, RT4, v2, v3, v4, ifIdEn, idKill, stallCount, stallError
    );

    modport slave (
        input  idRt, idWrite, idValid, stall, flush, memWait,
        output RT2, RT3, RT4, v2, v3, v4, ifIdEn, idKill, stallCount, stallError
    );
endinterface

// File: rtl/dest_reg_pipeline.sv
// rtl/dest_reg_pipeline.sv - EX/MEM/WB destination-register tracking with stall, flush, freeze and watchdog
module dest_reg_pipeline #(
    parameter int STALL_LIMIT = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dest_reg_pipeline_if.slave   bus
);
    localparam int CONS_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CONS_W-1:0] LIMIT = CONS_W'(STALL_LIMIT);

    logic [3:0]        rt2_q, rt3_q, rt4_q;
    logic              v2_q, v3_q, v4_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CONS_W-1:0] consec_q;
    logic              err_q;

    logic              counted;
    logic              take_id;
    logic [3:0]        rt2_d;
    logic              v2_d;
    logic [CONS_W-1:0] consec_inc;

    always_comb begin
        counted    = ~bus.memWait & ~bus.flush & bus.stall;
        take_id    = ~bus.flush & ~bus.stall & bus.idValid;
        // Register 0 is never a destination, so non-writing slots report 0.
        rt2_d      = (take_id & bus.idWrite) ? bus.idRt : 4'd0;
        v2_d       = take_id;
        consec_inc = (consec_q == LIMIT) ? consec_q : consec_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt2_q    <= 4'd0;
            rt3_q    <= 4'd0;
            rt4_q    <= 4'd0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            v4_q     <= 1'b0;
            cnt_q    <= '0;
            consec_q <= '0;
            err_q    <= 1'b0;
        end else if (!bus.memWait) begin
            rt2_q <= rt2_d;
            v2_q  <= v2_d;
            rt3_q <= rt2_q;
            v3_q  <= v2_q;
            rt4_q <= rt3_q;
            v4_q  <= v3_q;
            if (counted) begin
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                consec_q <= consec_inc;
                if (consec_inc == LIMIT) begin
                    err_q <= 1'b1;
                end
            end else begin
                consec_q <= '0;
            end
        end
    end

    assign bus.RT2        = rt2_q;
    assign bus.RT3        = rt3_q;
    assign bus.RT4        = rt4_q;
    assign bus.v2         = v2_q;
    assign bus.v3         = v3_q;
    assign bus.v4         = v4_q;
    assign bus.stallCount = cnt_q;
    assign bus.stallError = err_q;
    assign bus.ifIdEn     = ~bus.memWait & (bus.flush | ~bus.stall);
    assign bus.idKill     = ~bus.memWait & bus.flush;
endmodule

// File: tb/tb_dest_reg_pipeline.sv
// tb/tb_dest_reg_pipeline.sv - scoreboard bench with a queue-based pipeline reference model
module tb_dest_reg_pipeline;
    localparam int LIMIT = 2;
    localparam int CW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dest_reg_pipeline_if #(.CNT_W(CW)) bus ();
    dest_reg_pipeline #(.STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]    rt2, rt3, rt4;
        logic          v2, v3, v4;
        logic [CW-1:0] cnt;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference: stage list (index 0 = EX), unbounded counters clipped when reported.
    int   m_rt[3];
    bit   m_v[3];
    int   m_cnt;
    int   m_consec;
    bit   m_err;

    function automatic exp_t snap();
        exp_t e;
        e.rt2 = 4'(m_rt[0]); e.rt3 = 4'(m_rt[1]); e.rt4 = 4'(m_rt[2]);
        e.v2  = m_v[0];      e.v3  = m_v[1];      e.v4  = m_v[2];
        e.cnt = (m_cnt > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(m_cnt);
        e.err = m_err;
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rt[i] = 0;
            m_v[i]  = 1'b0;
        end
        m_cnt    = 0;
        m_consec = 0;
        m_err    = 1'b0;
    endfunction

    task automatic check_regs(input string name, input exp_t e);
        exp_t a;
        a.rt2 = bus.RT2; a.rt3 = bus.RT3; a.rt4 = bus.RT4;
        a.v2  = bus.v2;  a.v3  = bus.v3;  a.v4  = bus.v4;
        a.cnt = bus.stallCount;
        a.err = bus.stallError;
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got RT=%0d/%0d/%0d v=%b%b%b cnt=%0d err=%b, expected RT=%0d/%0d/%0d v=%b%b%b cnt=%0d err=%b",
                     name, a.rt2, a.rt3, a.rt4, a.v2, a.v3, a.v4, a.cnt, a.err,
                     e.rt2, e.rt3, e.rt4, e.v2, e.v3, e.v4, e.cnt, e.err);
        end
    endtask

    task automatic check_comb(input string name);
        logic exp_en, exp_kill;
        exp_en   = !bus.memWait && (bus.flush || !bus.stall);
        exp_kill = !bus.memWait && bus.flush;
        vectors++;
        if (bus.ifIdEn !== exp_en || bus.idKill !== exp_kill) begin
            miscompares++;
            $display("FAIL %s: got ifIdEn=%b idKill=%b, expected ifIdEn=%b idKill=%b",
                     name, bus.ifIdEn, bus.idKill, exp_en, exp_kill);
        end
    endtask

    // One cycle of stimulus: drive at negedge, advance the model, queue the post-edge expectation.
    task automatic step(input logic [3:0] rt, input logic wr, input logic vl,
                        input logic st, input logic fl, input logic mw);
        int new_rt;
        bit new_v;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.idRt    = rt;
        bus.idWrite = wr;
        bus.idValid = vl;
        bus.stall   = st;
        bus.flush   = fl;
        bus.memWait = mw;
        if (!mw) begin
            if (fl || st) begin
                new_rt = 0;
                new_v  = 1'b0;
            end else begin
                new_rt = (vl && wr) ? int'(rt) : 0;
                new_v  = vl;
            end
            m_rt[2] = m_rt[1]; m_v[2] = m_v[1];
            m_rt[1] = m_rt[0]; m_v[1] = m_v[0];
            m_rt[0] = new_rt;  m_v[0] = new_v;
            if (st && !fl) begin
                m_cnt++;
                m_consec++;
                if (m_consec >= LIMIT) m_err = 1'b1;
            end else begin
                m_consec = 0;
            end
        end
        sb.push_back(snap());
        #1;
        check_comb("comb");
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        check_regs("async_reset", snap());
        check_comb("comb_in_reset");
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) check_regs("pipe", sb.pop_front());
        end
    end

    initial begin : stimulus
        model_reset();
        bus.idRt    = 4'd0;
        bus.idWrite = 1'b0;
        bus.idValid = 1'b0;
        bus.stall   = 1'b1;
        bus.flush   = 1'b0;
        bus.memWait = 1'b0;
        #3;
        check_regs("reset_state", snap());
        check_comb("comb_reset");

        step(4'd5, 1, 1, 0, 0, 0);
        repeat (3) step(4'd0, 0, 0, 0, 0, 0);

        step(4'd7, 0, 1, 0, 0, 0);
        step(4'd0, 1, 1, 0, 0, 0);
        step(4'd0, 0, 0, 0, 0, 0);

        step(4'd3, 1, 1, 0, 0, 0);
        step(4'd8, 1, 1, 1, 0, 0);
        step(4'd0, 0, 0, 0, 0, 0);

        step(4'd9, 1, 1, 0, 0, 0);
        step(4'd9, 1, 1, 1, 1, 0);
        step(4'd9, 1, 1, 1, 1, 1);
        step(4'd9, 1, 1, 1, 0, 1);
        step(4'd0, 0, 0, 0, 0, 0);

        step(4'd1, 1, 1, 1, 0, 0);
        step(4'd1, 1, 1, 1, 0, 0);
        repeat (2) step(4'd0, 0, 0, 0, 0, 0);

        repeat (20) step(4'd2, 1, 1, 1, 0, 0);
        step(4'd0, 0, 0, 0, 0, 0);

        async_reset();
        repeat (9) step(4'd0, 0, 0, 1, 0, 0);
        step(4'd6, 1, 1, 0, 0, 0);
        step(4'd5, 1, 1, 0, 0, 0);
        step(4'd4, 1, 1, 0, 0, 0);
        async_reset();

        for (int n = 0; n < 400; n++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) < 3));
            if ($urandom_range(0, 99) == 0) async_reset();
        end
        step(4'd0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
